// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: counter mode encodings,
// signal levels and sequencer state encoding.
package counter_sequencer_pkg;

    localparam logic [1:0] CUENTA_MAS_UNO   = 2'b00;
    localparam logic [1:0] CUENTA_MENOS_UNO = 2'b01;
    localparam logic [1:0] CUENTA_TRES_TRES = 2'b10;
    localparam logic [1:0] CARGA_D          = 2'b11;

    localparam logic ALTO = 1'b1;
    localparam logic BAJO = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_RUN   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/counter32b.sv
// 32-bit multi-mode counter driven by the sequencer; RCO/LOAD are registered
// per enabled step and drop to BAJO on any non-enabled cycle.
module counter32b
    import counter_sequencer_pkg::*;
(
    input  logic        CLK,
    input  logic        ENABLE,
    input  logic        RESET,
    input  logic [1:0]  MODO,
    input  logic [31:0] D,
    output logic [31:0] Q,
    output logic        RCO,
    output logic        LOAD
);

    logic [32:0] nxt;

    // Next count with carry/borrow in bit 32
    always_comb begin
        nxt = {1'b0, Q};
        case (MODO)
            CUENTA_MAS_UNO:   nxt = {1'b0, Q} + 33'd1;
            CUENTA_MENOS_UNO: nxt = {1'b0, Q} - 33'd1;
            CUENTA_TRES_TRES: nxt = {1'b0, Q} + 33'd3;
            CARGA_D:          nxt = {1'b0, D};
            default:          nxt = {1'b0, Q};
        endcase
    end

    // Count register; clears synchronously while RESET is BAJO
    always_ff @(posedge CLK) begin
        if (RESET == BAJO) begin
            Q    <= 32'd0;
            RCO  <= BAJO;
            LOAD <= BAJO;
        end else if (ENABLE == ALTO) begin
            Q    <= nxt[31:0];
            RCO  <= nxt[32];
            LOAD <= (MODO == CARGA_D) ? ALTO : BAJO;
        end else begin
            Q    <= Q;
            RCO  <= BAJO;
            LOAD <= BAJO;
        end
    end

endmodule

// File: rtl/counter_sequencer_rr_arbiter2.sv
// Two-way round-robin grant; the pointer favours the requester that was not
// granted last and only matters when both request together.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic       grant_valid,
    output logic       grant_idx
);

    logic ptr;

    // Grant selection
    always_comb begin
        grant_valid = valid[0] | valid[1];
        grant_idx   = 1'b0;
        case (valid)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ptr;
            default: grant_idx = 1'b0;
        endcase
    end

    // Pointer moves away from the winner on the accepting cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= ~grant_idx;
        end else begin
            ptr <= ptr;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Command sequencer in front of counter32b: arbitrates two requesters, runs the
// counter for the requested cycles and reports final count and flags.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [1:0]         REQ_VALID,
    output logic [1:0]         REQ_READY,
    input  logic [3:0]         REQ_MODO,
    input  logic [63:0]        REQ_D,
    input  logic [2*LEN_W-1:0] REQ_LEN,
    output logic               CNT_ENABLE,
    output logic               CNT_RESET,
    output logic [1:0]         CNT_MODO,
    output logic [31:0]        CNT_D,
    input  logic [31:0]        CNT_Q,
    input  logic               CNT_RCO,
    input  logic               CNT_LOAD,
    output logic               DONE_VALID,
    input  logic               DONE_READY,
    output logic               DONE_ID,
    output logic [31:0]        DONE_Q,
    output logic               DONE_OVF,
    output logic               DONE_ERR
);

    localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    seq_state_t       state;
    logic             grant_valid;
    logic             grant_idx;
    logic             handshake;
    logic             cur_id;
    logic             ovf_acc;
    logic [LEN_W-1:0] lat_len;
    logic [LEN_W-1:0] run_cnt;
    logic [1:0]       sel_modo;
    logic [31:0]      sel_d;
    logic [LEN_W-1:0] sel_len;

    rr_arbiter2 u_arb (
        .clk         (CLK),
        .reset       (RESET),
        .valid       (REQ_VALID),
        .accept      (handshake),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign sel_modo  = grant_idx ? REQ_MODO[3:2] : REQ_MODO[1:0];
    assign sel_d     = grant_idx ? REQ_D[63:32]  : REQ_D[31:0];
    assign sel_len   = grant_idx ? REQ_LEN[2*LEN_W-1:LEN_W] : REQ_LEN[LEN_W-1:0];
    assign handshake = |(REQ_READY & REQ_VALID);
    // The counter is cleared exactly while we are held in reset
    assign CNT_RESET = RESET ? BAJO : ALTO;

    // Accept is offered only from IDLE and never while in reset
    always_comb begin
        REQ_READY = 2'b00;
        if ((state == ST_IDLE) && !RESET && grant_valid) begin
            REQ_READY = onehot2(grant_idx);
        end else begin
            REQ_READY = 2'b00;
        end
    end

    // Sequencer FSM with registered counter controls and completion outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            CNT_ENABLE <= 1'b0;
            CNT_MODO   <= CUENTA_MAS_UNO;
            CNT_D      <= 32'd0;
            lat_len    <= LEN_ZERO;
            run_cnt    <= LEN_ZERO;
            cur_id     <= 1'b0;
            ovf_acc    <= 1'b0;
            DONE_VALID <= 1'b0;
            DONE_ID    <= 1'b0;
            DONE_Q     <= 32'd0;
            DONE_OVF   <= 1'b0;
            DONE_ERR   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        CNT_MODO <= sel_modo;
                        CNT_D    <= sel_d;
                        lat_len  <= sel_len;
                        cur_id   <= grant_idx;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    ovf_acc <= 1'b0;
                    if (CNT_MODO == CARGA_D) begin
                        run_cnt    <= LEN_ONE;
                        CNT_ENABLE <= 1'b1;
                        state      <= ST_RUN;
                    end else if (lat_len == LEN_ZERO) begin
                        state <= ST_WAIT;
                    end else begin
                        run_cnt    <= lat_len;
                        CNT_ENABLE <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Compare against one so a full-scale length never wraps
                    if (CNT_RCO) begin
                        ovf_acc <= 1'b1;
                    end
                    if (run_cnt == LEN_ONE) begin
                        CNT_ENABLE <= 1'b0;
                        state      <= ST_WAIT;
                    end else begin
                        run_cnt <= run_cnt - LEN_ONE;
                    end
                end
                ST_WAIT: begin
                    DONE_Q     <= CNT_Q;
                    DONE_OVF   <= ovf_acc | CNT_RCO;
                    DONE_ERR   <= (CNT_MODO == CARGA_D) && (CNT_LOAD == BAJO);
                    DONE_ID    <= cur_id;
                    DONE_VALID <= 1'b1;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    if (DONE_READY) begin
                        DONE_VALID <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    CNT_ENABLE <= 1'b0;
                    DONE_VALID <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer with a real counter32b behind it; expected
// results come from an arithmetic model of the command stream.
module tb_counter_sequencer;

    localparam int LEN_W = 8;

    logic               CLK = 1'b0;
    logic               RESET;
    logic [1:0]         REQ_VALID;
    logic [1:0]         REQ_READY;
    logic [3:0]         REQ_MODO;
    logic [63:0]        REQ_D;
    logic [2*LEN_W-1:0] REQ_LEN;
    logic               CNT_ENABLE, CNT_RESET, CNT_RCO, CNT_LOAD;
    logic [1:0]         CNT_MODO;
    logic [31:0]        CNT_D, CNT_Q;
    logic               DONE_VALID, DONE_READY, DONE_ID, DONE_OVF, DONE_ERR;
    logic [31:0]        DONE_Q;

    int     checks = 0;
    int     errors = 0;
    longint model_q = 0;
    bit     model_ptr = 1'b0;

    always #5 CLK = ~CLK;

    counter_sequencer #(.LEN_W(LEN_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_MODO(REQ_MODO),
        .REQ_D(REQ_D), .REQ_LEN(REQ_LEN),
        .CNT_ENABLE(CNT_ENABLE), .CNT_RESET(CNT_RESET), .CNT_MODO(CNT_MODO),
        .CNT_D(CNT_D), .CNT_Q(CNT_Q), .CNT_RCO(CNT_RCO), .CNT_LOAD(CNT_LOAD),
        .DONE_VALID(DONE_VALID), .DONE_READY(DONE_READY), .DONE_ID(DONE_ID),
        .DONE_Q(DONE_Q), .DONE_OVF(DONE_OVF), .DONE_ERR(DONE_ERR)
    );

    counter32b u_cnt (
        .CLK(CLK), .ENABLE(CNT_ENABLE), .RESET(CNT_RESET), .MODO(CNT_MODO),
        .D(CNT_D), .Q(CNT_Q), .RCO(CNT_RCO), .LOAD(CNT_LOAD)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input bit id, input logic [1:0] mode, input logic [31:0] d, input int len);
        if (id) begin
            REQ_MODO[3:2]              = mode;
            REQ_D[63:32]               = d;
            REQ_LEN[2*LEN_W-1:LEN_W]   = len[LEN_W-1:0];
        end else begin
            REQ_MODO[1:0]              = mode;
            REQ_D[31:0]                = d;
            REQ_LEN[LEN_W-1:0]         = len[LEN_W-1:0];
        end
    endtask

    // Issue one command from requester id, follow it to DONE, check, then accept.
    task automatic run(input bit id, input logic [1:0] mode, input logic [31:0] d,
                       input int len, input int stall);
        int     waited;
        int     k;
        int     en;
        int     lcyc;
        longint nq;
        bit     novf;
        set_fields(id, mode, d, len);
        REQ_VALID[id] = 1'b1;
        waited = 0;
        #1;
        while (!REQ_READY[id] && waited < 300) begin
            @(negedge CLK);
            #1;
            waited++;
        end
        check($sformatf("grant_req%0d", id), {62'd0, REQ_READY}, id ? 64'd2 : 64'd1);
        if (!REQ_READY[id]) begin
            REQ_VALID[id] = 1'b0;
            return;
        end
        @(posedge CLK);
        model_ptr = ~id;
        @(negedge CLK);
        REQ_VALID[id] = 1'b0;

        if (mode == 2'b11) begin
            lcyc = 1;
            nq   = longint'(d);
            novf = 1'b0;
        end else begin
            lcyc = len;
            case (mode)
                2'b00:   nq = model_q + len;
                2'b01:   nq = model_q - len;
                default: nq = model_q + 3 * len;
            endcase
            novf = (nq < 0) || (nq > 64'sh0000_0000_FFFF_FFFF);
            nq   = nq & 64'sh0000_0000_FFFF_FFFF;
        end

        k  = 1;
        en = 0;
        while (!DONE_VALID && k < 600) begin
            if (CNT_ENABLE) en++;
            @(negedge CLK);
            k++;
        end
        check("done_latency", 64'(k), 64'(lcyc + 3));
        check("enable_cycles", 64'(en), 64'(lcyc));
        check("done_id", {63'd0, DONE_ID}, {63'd0, id});
        check("done_q", {32'd0, DONE_Q}, 64'(nq));
        check("done_ovf", {63'd0, DONE_OVF}, {63'd0, novf});
        check("done_err", {63'd0, DONE_ERR}, 64'd0);
        model_q = nq;

        if (stall > 0) begin
            REQ_VALID[~id] = 1'b1;
            for (int s = 0; s < stall; s++) begin
                @(negedge CLK);
                check("stall_valid", {63'd0, DONE_VALID}, 64'd1);
                check("stall_q", {32'd0, DONE_Q}, 64'(nq));
                check("stall_ready", {62'd0, REQ_READY}, 64'd0);
            end
            REQ_VALID[~id] = 1'b0;
        end
        DONE_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        DONE_READY = 1'b0;
        check("done_cleared", {63'd0, DONE_VALID}, 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int     seen;
        int     waited;
        bit     first;
        logic [1:0]  m0, m1;
        logic [31:0] d0, d1;
        int     l0, l1;

        RESET      = 1'b1;
        REQ_VALID  = 2'b01;
        REQ_MODO   = 4'd0;
        REQ_D      = 64'd0;
        REQ_LEN    = '0;
        DONE_READY = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_ready", {62'd0, REQ_READY}, 64'd0);
        check("rst_cnt_reset", {63'd0, CNT_RESET}, 64'd0);
        check("rst_enable", {63'd0, CNT_ENABLE}, 64'd0);
        check("rst_modo", {62'd0, CNT_MODO}, 64'd0);
        check("rst_d", {32'd0, CNT_D}, 64'd0);
        check("rst_done_valid", {63'd0, DONE_VALID}, 64'd0);
        check("rst_done_fields", {29'd0, DONE_ID, DONE_OVF, DONE_ERR, DONE_Q}, 64'd0);
        REQ_VALID = 2'b00;
        RESET     = 1'b0;
        #1;
        check("cnt_reset_released", {63'd0, CNT_RESET}, 64'd1);
        @(negedge CLK);

        // Directed scenarios from the command rules
        run(1'b0, 2'b00, 32'd0, 5, 0);
        run(1'b1, 2'b11, 32'hFFFF_FFFE, 0, 0);
        run(1'b1, 2'b00, 32'd0, 3, 0);

        first = model_ptr;
        check("ptr_before_pair", {63'd0, first}, 64'd0);
        set_fields(~first, 2'b01, 32'd0, 1);
        REQ_VALID[~first] = 1'b1;
        run(first, 2'b10, 32'd0, 2, 0);
        run(~first, 2'b01, 32'd0, 1, 0);

        run(1'b0, 2'b00, 32'd0, 0, 0);
        run(1'b0, 2'b10, 32'd0, 4, 10);
        run(1'b1, 2'b00, 32'd0, (1 << LEN_W) - 1, 0);
        run(1'b0, 2'b11, 32'd0, 7, 0);
        run(1'b1, 2'b01, 32'd0, 2, 0);

        // Abort mid-run with reset
        set_fields(1'b0, 2'b00, 32'd0, 100);
        REQ_VALID = 2'b01;
        waited = 0;
        #1;
        while (!REQ_READY[0] && waited < 50) begin
            @(negedge CLK);
            #1;
            waited++;
        end
        check("abort_grant", {62'd0, REQ_READY}, 64'd1);
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 2'b00;
        repeat (20) @(negedge CLK);
        check("abort_mid_enable", {63'd0, CNT_ENABLE}, 64'd1);
        RESET = 1'b1;
        #1;
        check("abort_cnt_reset", {63'd0, CNT_RESET}, 64'd0);
        @(posedge CLK);
        #1;
        check("abort_enable", {63'd0, CNT_ENABLE}, 64'd0);
        check("abort_done_valid", {63'd0, DONE_VALID}, 64'd0);
        check("abort_cnt_q", {32'd0, CNT_Q}, 64'd0);
        @(negedge CLK);
        RESET     = 1'b0;
        model_q   = 0;
        model_ptr = 1'b0;
        seen = 0;
        repeat (110) begin
            @(negedge CLK);
            if (DONE_VALID || CNT_ENABLE) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        run(1'b0, 2'b00, 32'd0, 4, 0);

        // Randomized command stream, sometimes with both requesters together
        for (int i = 0; i < 30; i++) begin
            m0 = 2'($urandom_range(0, 3));
            m1 = 2'($urandom_range(0, 3));
            d0 = $urandom;
            d1 = $urandom;
            l0 = int'($urandom_range(0, 15));
            l1 = int'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                first = model_ptr;
                set_fields(~first, m1, d1, l1);
                REQ_VALID[~first] = 1'b1;
                run(first, m0, d0, l0, 0);
                run(~first, m1, d1, l1, 0);
            end else begin
                run(1'($urandom_range(0, 1)), m0, d0, l0, int'($urandom_range(0, 2)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
